// File: rtl/controller_spi_tx.sv
// controller_spi_tx: serializes a {sync, buttons, joystick x, joystick y}
// snapshot onto a two-wire clock/data link, MSB first, with a fixed idle gap
// between back-to-back frames. Data only changes while the serial clock is
// low, so the receiver samples on the rising edge.
//
// Handshake: there is no valid/ready pair here. enable_in is a level request
// sampled only in IDLE or on the last gap cycle; busy_out is the
// "frame in flight" indicator and frame_done_out is a one-cycle completion
// strobe that needs no acknowledge.
module controller_spi_tx #(
  parameter int         CLK_DIV    = 50,
  parameter int         GAP_CYCLES = 1000,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic [7:0] buttons_in,
  input  logic [7:0] joystick_x_in,
  input  logic [7:0] joystick_y_in,
  output logic       chip_clk_out,
  output logic       chip_data_out,
  output logic       busy_out,
  output logic       frame_done_out
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT_LO = 2'd1;
  localparam logic [1:0] SHIFT_HI = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  // One phase counter serves both the half-bit timing and the gap timing.
  localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] phase_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   shreg;
  logic [31:0]   snapshot;

  // Frame image captured at frame start; later input changes are ignored.
  assign snapshot = {SYNC_BYTE, buttons_in, joystick_x_in, joystick_y_in};

  // Frame sequencer: all outputs are registered here, reset clears everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      phase_cnt      <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      chip_clk_out   <= 1'b0;
      chip_data_out  <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      case (state)
        IDLE: begin
          chip_clk_out  <= 1'b0;
          chip_data_out <= 1'b0;
          busy_out      <= 1'b0;
          if (enable_in) begin
            shreg         <= snapshot;
            chip_data_out <= snapshot[31];
            busy_out      <= 1'b1;
            bit_cnt       <= 5'd31;
            phase_cnt     <= '0;
            state         <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_cnt == DIV_LAST) begin
            phase_cnt    <= '0;
            chip_clk_out <= 1'b1;
            state        <= SHIFT_HI;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (phase_cnt == DIV_LAST) begin
            phase_cnt    <= '0;
            chip_clk_out <= 1'b0;
            if (bit_cnt != 5'd0) begin
              // Next bit goes out together with the falling clock edge.
              shreg         <= {shreg[30:0], 1'b0};
              chip_data_out <= shreg[30];
              bit_cnt       <= bit_cnt - 5'd1;
              state         <= SHIFT_LO;
            end else begin
              frame_done_out <= 1'b1;
              chip_data_out  <= 1'b0;
              state          <= GAP;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        GAP: begin
          if (phase_cnt == GAP_LAST) begin
            phase_cnt <= '0;
            if (enable_in) begin
              // Back-to-back frame: busy stays high across the boundary.
              shreg         <= snapshot;
              chip_data_out <= snapshot[31];
              bit_cnt       <= 5'd31;
              state         <= SHIFT_LO;
            end else begin
              busy_out <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_spi_tx.sv
// Bench for controller_spi_tx with CLK_DIV=2, GAP_CYCLES=4: a clk_in-domain
// receiver decodes each frame into a scoreboard, plus directed sequences for
// start latency, back-to-back frames, async reset, enable drop and data
// stability over random frames.
module tb_controller_spi_tx;

  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       enable_in = 1'b0;
  logic [7:0] buttons_in = 8'h00;
  logic [7:0] joystick_x_in = 8'h00;
  logic [7:0] joystick_y_in = 8'h00;
  logic       chip_clk_out;
  logic       chip_data_out;
  logic       busy_out;
  logic       frame_done_out;

  controller_spi_tx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .enable_in     (enable_in),
    .buttons_in    (buttons_in),
    .joystick_x_in (joystick_x_in),
    .joystick_y_in (joystick_y_in),
    .chip_clk_out  (chip_clk_out),
    .chip_data_out (chip_data_out),
    .busy_out      (busy_out),
    .frame_done_out(frame_done_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- receiver / scoreboard ----------------
  logic [31:0] rx = '0;
  int          rises = 0;
  int          done_cnt = 0;
  int          stab_err = 0;
  logic        prev_clk = 1'b0;
  logic        prev_data = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      rx = '0;
      rises = 0;
      prev_clk = 1'b0;
      prev_data = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (chip_clk_out && !prev_clk) begin
        rx = {rx[30:0], chip_data_out};
        rises++;
      end
      if (chip_clk_out && prev_clk && (chip_data_out != prev_data)) stab_err++;
      if (frame_done_out) begin
        done_cnt++;
        check("done_width", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", rx, 32'hFFFF_FFFF);
        end else begin
          check("frame", rx, exp_q.pop_front());
          check("rise_count", rises, 32);
        end
        rises = 0;
      end
      prev_clk  = chip_clk_out;
      prev_data = chip_data_out;
      prev_done = frame_done_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
    buttons_in    = b;
    joystick_x_in = x;
    joystick_y_in = y;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk_in); #2;
      n++;
    end
    if (done_cnt == d0) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int n = 0;
    while (rises < target && n < budget) begin
      @(posedge clk_in); #2;
      n++;
    end
    if (rises < target) check(name, rises, target);
  endtask

  task automatic wait_done_pin(input int budget, input string name);
    int n = 0;
    while (!frame_done_out && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (!frame_done_out) check(name, 32'd0, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [31:0] frame;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int d0;
    int cnt;
    int lows;
    int d1_cyc;
    int d2_cyc;
    int seen;
    logic [7:0] rb, rx8, ry;

    vecs[0] = '{8'h81, 8'h7F, 8'h00, 32'hA5817F00};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 32'hA5FF00FF};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 32'hA500FF00};
    vecs[3] = '{8'hC3, 8'h10, 8'hF0, 32'hA5C310F0};

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_clk", {31'd0, chip_clk_out}, 32'd0);
    check("rst_data", {31'd0, chip_data_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_done", {31'd0, frame_done_out}, 32'd0);
    @(posedge clk_in); #1 rst_in = 1'b0;

    // Start latency: enable sampled at edge N
    @(posedge clk_in); #1;
    set_inputs(8'h81, 8'h7F, 8'h00);
    enable_in = 1'b1;
    exp_q.push_back(32'hA5817F00);
    d0 = done_cnt;
    @(posedge clk_in); #1 enable_in = 1'b0;   // edge N
    @(negedge clk_in);
    check("start_busy", {31'd0, busy_out}, 32'd1);
    check("start_data", {31'd0, chip_data_out}, 32'd1);
    check("start_clk_n", {31'd0, chip_clk_out}, 32'd0);
    @(negedge clk_in);
    check("start_clk_n1", {31'd0, chip_clk_out}, 32'd0);
    @(negedge clk_in);
    check("start_clk_n2", {31'd0, chip_clk_out}, 32'd1);
    wait_done(d0, 400, "start_timeout");
    repeat (6) @(posedge clk_in); #2;
    check("start_idle_busy", {31'd0, busy_out}, 32'd0);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      set_inputs(vecs[i].b, vecs[i].x, vecs[i].y);
      enable_in = 1'b1;
      exp_q.push_back(vecs[i].frame);
      d0 = done_cnt;
      @(posedge clk_in); #1 enable_in = 1'b0;
      set_inputs(8'h55, 8'h55, 8'h55);   // must not leak into the frame
      wait_done(d0, 400, "vec_timeout");
      repeat (20) @(posedge clk_in); #2;
      check("vec_idle_busy", {31'd0, busy_out}, 32'd0);
      check("vec_idle_clk", {31'd0, chip_clk_out}, 32'd0);
      check("vec_idle_data", {31'd0, chip_data_out}, 32'd0);
      check("vec_done_count", done_cnt, d0 + 1);
    end

    // Continuous mode with a mid-frame input change
    @(posedge clk_in); #1;
    set_inputs(8'h01, 8'h11, 8'h22);
    enable_in = 1'b1;
    exp_q.push_back(32'hA5011122);
    @(posedge clk_in); #1;
    lows = 0; seen = 0; d1_cyc = 0; d2_cyc = 0; cnt = 0;
    while (seen < 2 && cnt < 600) begin
      @(negedge clk_in);
      cnt++;
      if (!busy_out) lows++;
      if (rises == 10 && buttons_in == 8'h01 && seen == 0) begin
        buttons_in = 8'h02;
        exp_q.push_back(32'hA5021122);
      end
      if (frame_done_out) begin
        seen++;
        if (seen == 1) d1_cyc = cyc;
        else begin
          d2_cyc = cyc;
          enable_in = 1'b0;
        end
      end
    end
    check("cont_frames", seen, 2);
    check("cont_busy_lows", lows, 0);
    check("cont_period", d2_cyc - d1_cyc, 64 * CLK_DIV + GAP_CYCLES);
    repeat (10) @(posedge clk_in); #2;
    check("cont_idle", {31'd0, busy_out}, 32'd0);

    // Async reset mid-frame, then a full frame with enable still high
    @(posedge clk_in); #1;
    set_inputs(8'h3C, 8'h5A, 8'h99);
    enable_in = 1'b1;
    wait_rises(15, 400, "rst_rise_timeout");
    d0 = done_cnt;
    @(posedge clk_in); #3 rst_in = 1'b1;
    #1;
    check("arst_clk", {31'd0, chip_clk_out}, 32'd0);
    check("arst_data", {31'd0, chip_data_out}, 32'd0);
    check("arst_busy", {31'd0, busy_out}, 32'd0);
    check("arst_done", {31'd0, frame_done_out}, 32'd0);
    repeat (3) @(posedge clk_in);
    #4 rst_in = 1'b0;
    check("arst_no_done", done_cnt, d0);
    exp_q.push_back(32'hA53C5A99);
    wait_done_pin(400, "arst_timeout");
    enable_in = 1'b0;
    repeat (10) @(posedge clk_in); #2;
    check("arst_idle", {31'd0, busy_out}, 32'd0);

    // Enable drop at bit 5: frame completes, busy falls GAP cycles later
    @(posedge clk_in); #1;
    set_inputs(8'hE7, 8'h01, 8'h80);
    enable_in = 1'b1;
    exp_q.push_back(32'hA5E70180);
    wait_rises(5, 400, "drop_rise_timeout");
    enable_in = 1'b0;
    d0 = done_cnt;
    wait_done_pin(400, "drop_timeout");
    cnt = 0;
    while (busy_out && cnt < 20) begin
      @(negedge clk_in);
      cnt++;
    end
    check("drop_busy_fall", cnt, GAP_CYCLES);
    lows = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (busy_out) lows++;
    end
    check("drop_no_restart", lows, 0);
    check("drop_done_count", done_cnt, d0 + 1);

    // Random back-to-back frames: inputs change during each gap
    stab_err = 0;
    @(posedge clk_in); #1;
    rb = 8'($urandom_range(0, 255)); rx8 = 8'($urandom_range(0, 255)); ry = 8'($urandom_range(0, 255));
    set_inputs(rb, rx8, ry);
    exp_q.push_back({8'hA5, rb, rx8, ry});
    enable_in = 1'b1;
    for (int f = 0; f < 200; f++) begin
      @(negedge clk_in);
      wait_done_pin(400, "rand_timeout");
      if (f < 199) begin
        rb = 8'($urandom_range(0, 255)); rx8 = 8'($urandom_range(0, 255)); ry = 8'($urandom_range(0, 255));
        set_inputs(rb, rx8, ry);
        exp_q.push_back({8'hA5, rb, rx8, ry});
      end else begin
        enable_in = 1'b0;
      end
    end
    repeat (10) @(posedge clk_in); #2;
    check("rand_stability", stab_err, 0);
    check("rand_idle", {31'd0, busy_out}, 32'd0);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
